// File: rtl/barami_pkg.sv
// Shared instruction-packet layout and reservation-station slot type.
package barami_pkg;
    localparam int INST_W  = 116;
    localparam int CTRL_W  = 13;
    localparam int RD_W    = 5;
    localparam int DATA_W  = 32;
    localparam int RS_TAGW = 5;

    // Field offsets inside the packed decomposed instruction (LSB first).
    localparam int RD_LSB   = 0;
    localparam int S1V_BIT  = 5;
    localparam int RS1_LSB  = 6;
    localparam int S2V_BIT  = 38;
    localparam int RS2_LSB  = 39;
    localparam int CTRL_LSB = 71;
    localparam int MEM_LSB  = 84;

    typedef struct packed {
        logic              valid;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] memdata;
        logic [DATA_W-1:0] rs1;
        logic              v1;
        logic [DATA_W-1:0] rs2;
        logic              v2;
    } rs_slot_t;

    // Low-order mask selecting the tag bits of a pending operand field.
    function automatic logic [DATA_W-1:0] tag_mask(input int w);
        return DATA_W'((64'd1 << w) - 64'd1);
    endfunction

    // Turn an incoming packet into an occupied slot.
    function automatic rs_slot_t unpack_inst(input logic [INST_W-1:0] inst);
        rs_slot_t s;
        s.valid   = 1'b1;
        s.rd      = inst[RD_LSB +: RD_W];
        s.v1      = inst[S1V_BIT];
        s.rs1     = inst[RS1_LSB +: DATA_W];
        s.v2      = inst[S2V_BIT];
        s.rs2     = inst[RS2_LSB +: DATA_W];
        s.ctrl    = inst[CTRL_LSB +: CTRL_W];
        s.memdata = inst[MEM_LSB +: DATA_W];
        return s;
    endfunction

    // Capture a broadcast result into any pending operand whose tag matches.
    // A store-data operand (rs2) also refreshes memdata.
    function automatic rs_slot_t rs_wake(input rs_slot_t e, input logic cv,
                                         input logic [DATA_W-1:0] tag,
                                         input logic [DATA_W-1:0] data,
                                         input logic [DATA_W-1:0] mask);
        rs_slot_t r;
        r = e;
        if (cv && e.valid && !e.v1 && ((e.rs1 & mask) == tag)) begin
            r.rs1 = data;
            r.v1  = 1'b1;
        end
        if (cv && e.valid && !e.v2 && ((e.rs2 & mask) == tag)) begin
            r.rs2     = data;
            r.v2      = 1'b1;
            r.memdata = data;
        end
        return r;
    endfunction
endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: stored state plus its CDB wakeup view.
module rs_entry
    import barami_pkg::*;
#(
    parameter int TAGW = RS_TAGW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cdb_valid_i,
    input  logic [TAGW-1:0]   cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    input  rs_slot_t          entry_d_i,
    output rs_slot_t          entry_q_o,
    output rs_slot_t          woken_o
);
    localparam logic [DATA_W-1:0] TAG_MASK = tag_mask(TAGW);

    rs_slot_t entry_q;

    // Slot register; the top decides what each slot holds next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= '0;
        else        entry_q <= entry_d_i;
    end

    assign entry_q_o = entry_q;
    assign woken_o   = rs_wake(entry_q, cdb_valid_i, DATA_W'(cdb_tag_i), cdb_data_i, TAG_MASK);
endmodule

// File: rtl/reservation_station.sv
// Age-ordered reservation station: oldest-ready issue with compaction.
module reservation_station
    import barami_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = RS_TAGW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [INST_W-1:0]      in_inst,
    output logic                   in_ready,
    input  logic                   cdb_valid,
    input  logic [TAGW-1:0]        cdb_tag,
    input  logic [DATA_W-1:0]      cdb_data,
    input  logic                   flush,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [DATA_W-1:0]      issue_rs1,
    output logic [DATA_W-1:0]      issue_rs2,
    output logic [DATA_W-1:0]      issue_memdata,
    output logic [CTRL_W-1:0]      issue_ctrl,
    output logic [RD_W-1:0]        issue_rd,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] TAG_MASK = tag_mask(TAGW);

    logic [CW-1:0] count_q, count_d, keep_cnt, sel_idx;
    logic          any_ready, enq, fire;
    rs_slot_t      slot_q [DEPTH];
    rs_slot_t      slot_w [DEPTH];
    rs_slot_t      enq_slot, sel_slot;

    assign in_ready = (count_q < CW'(DEPTH)) && !flush;
    assign enq      = in_valid && in_ready;
    // Incoming instruction snoops the same-cycle broadcast before it is stored.
    assign enq_slot = rs_wake(unpack_inst(in_inst), cdb_valid, DATA_W'(cdb_tag), cdb_data, TAG_MASK);

    // Select the lowest-index (oldest) entry whose stored operands are both valid.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        sel_slot  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_q[i].valid && slot_q[i].v1 && slot_q[i].v2) begin
                any_ready = 1'b1;
                sel_idx   = CW'(i);
                sel_slot  = slot_q[i];
            end
        end
    end

    assign issue_valid   = any_ready && !flush;
    assign fire          = issue_valid && issue_ready;
    assign keep_cnt      = count_q - CW'(fire);
    assign issue_rs1     = issue_valid ? sel_slot.rs1     : '0;
    assign issue_rs2     = issue_valid ? sel_slot.rs2     : '0;
    assign issue_memdata = issue_valid ? sel_slot.memdata : '0;
    assign issue_ctrl    = issue_valid ? sel_slot.ctrl    : '0;
    assign issue_rd      = issue_valid ? sel_slot.rd      : '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            rs_slot_t shift_src, slot_d;

            if (gi < DEPTH - 1) begin : g_shift
                assign shift_src = slot_w[gi+1];
            end else begin : g_last
                assign shift_src = '0;
            end

            // Next content: keep (with wakeup), shift down past the issued
            // entry, or take the new instruction at the first free slot.
            always_comb begin
                slot_d = slot_w[gi];
                if (flush)
                    slot_d = '0;
                else if (enq && keep_cnt == CW'(gi))
                    slot_d = enq_slot;
                else if (fire && CW'(gi) >= sel_idx)
                    slot_d = shift_src;
            end

            rs_entry #(.TAGW(TAGW)) u_entry (
                .clk        (clk),
                .rst_n      (rst_n),
                .cdb_valid_i(cdb_valid),
                .cdb_tag_i  (cdb_tag),
                .cdb_data_i (cdb_data),
                .entry_d_i  (slot_d),
                .entry_q_o  (slot_q[gi]),
                .woken_o    (slot_w[gi])
            );
        end
    endgenerate

    assign count_d = flush ? '0 : keep_cnt + CW'(enq);

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: tb/tb_reservation_station.sv
// Randomised and directed bench for reservation_station with a queue model.
module tb_reservation_station;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [115:0] in_inst;
    logic         in_ready;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         flush;
    logic         issue_valid;
    logic         issue_ready;
    logic [31:0]  issue_rs1, issue_rs2, issue_memdata;
    logic [12:0]  issue_ctrl;
    logic [4:0]   issue_rd;
    logic [2:0]   count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .TAGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .flush(flush), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_memdata(issue_memdata), .issue_ctrl(issue_ctrl), .issue_rd(issue_rd),
        .count(count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [12:0] ctrl;
        logic [31:0] mem;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        v1;
        logic        v2;
    } ment_t;

    ment_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [115:0] mk(input logic [31:0] mem, input logic [12:0] ctrl,
                                        input logic [31:0] rs2, input logic v2,
                                        input logic [31:0] rs1, input logic v1,
                                        input logic [4:0] rd);
        return {mem, ctrl, rs2, v2, rs1, v1, rd};
    endfunction

    // Broadcast capture as the rules describe it, using the current CDB inputs.
    function automatic ment_t mwake(input ment_t e);
        ment_t r;
        r = e;
        if (cdb_valid && !e.v1 && e.rs1[4:0] == cdb_tag) begin
            r.rs1 = cdb_data; r.v1 = 1'b1;
        end
        if (cdb_valid && !e.v2 && e.rs2[4:0] == cdb_tag) begin
            r.rs2 = cdb_data; r.v2 = 1'b1; r.mem = cdb_data;
        end
        return r;
    endfunction

    // Model state update: issue oldest ready, wake everyone, append new entry.
    always @(posedge clk or negedge rst_n) begin
        int    idx;
        ment_t e;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            idx = -1;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].v1 && mq[i].v2) idx = i;
            for (int i = 0; i < mq.size(); i++) mq[i] = mwake(mq[i]);
            if (issue_ready && idx >= 0) mq.delete(idx);
            if (in_valid && (mq.size() + ((issue_ready && idx >= 0) ? 1 : 0)) < DEPTH) begin
                e.rd   = in_inst[4:0];
                e.v1   = in_inst[5];
                e.rs1  = in_inst[37:6];
                e.v2   = in_inst[38];
                e.rs2  = in_inst[70:39];
                e.ctrl = in_inst[83:71];
                e.mem  = in_inst[115:84];
                mq.push_back(mwake(e));
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        int idx;
        idx = -1;
        if (!flush)
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].v1 && mq[i].v2) idx = i;
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH && !flush));
        chk("issue_valid", 64'(issue_valid), 64'(idx >= 0));
        if (idx >= 0) begin
            chk("issue_rs1", 64'(issue_rs1), 64'(mq[idx].rs1));
            chk("issue_rs2", 64'(issue_rs2), 64'(mq[idx].rs2));
            chk("issue_memdata", 64'(issue_memdata), 64'(mq[idx].mem));
            chk("issue_ctrl", 64'(issue_ctrl), 64'(mq[idx].ctrl));
            chk("issue_rd", 64'(issue_rd), 64'(mq[idx].rd));
        end else begin
            chk("idle_payload", {issue_rs1, issue_rs2 ^ issue_memdata ^ {14'd0, issue_ctrl, issue_rd}}, 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic        v1, v2;
        logic [31:0] rs1, rs2;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; cdb_valid = 1'b0; cdb_tag = '0;
        cdb_data = '0; flush = 1'b0; issue_ready = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        cyc(); rst_n = 1'b1;

        // Both operands ready: issues the cycle after enqueue.
        in_valid = 1'b1; issue_ready = 1'b1;
        in_inst = mk(32'h0, 13'h1, 32'h7, 1'b1, 32'h5, 1'b1, 5'd1);
        cyc(); in_valid = 1'b0; #1;
        chk("d1_valid", 64'(issue_valid), 64'd1);
        chk("d1_rs1", 64'(issue_rs1), 64'h5);
        chk("d1_rs2", 64'(issue_rs2), 64'h7);
        cyc(); #1;
        chk("d1_count", 64'(count), 64'd0);

        // rs1 waits on tag 3; broadcast two cycles later.
        in_valid = 1'b1;
        in_inst = mk(32'h0, 13'h2, 32'h9, 1'b1, 32'h3, 1'b0, 5'd2);
        cyc(); in_valid = 1'b0; #1;
        chk("d2_wait", 64'(issue_valid), 64'd0);
        cyc(); cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'hDEADBEEF; #1;
        chk("d2_wake_cycle", 64'(issue_valid), 64'd0);
        cyc(); cdb_valid = 1'b0; #1;
        chk("d2_valid", 64'(issue_valid), 64'd1);
        chk("d2_rs1", 64'(issue_rs1), 64'hDEADBEEF);
        cyc();

        // Enqueue alongside a matching broadcast on rs2.
        issue_ready = 1'b0; in_valid = 1'b1;
        in_inst = mk(32'hAAAA, 13'h3, 32'h4, 1'b0, 32'h1, 1'b1, 5'd3);
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'h10;
        cyc(); in_valid = 1'b0; cdb_valid = 1'b0; #1;
        chk("d3_valid", 64'(issue_valid), 64'd1);
        chk("d3_rs2", 64'(issue_rs2), 64'h10);
        chk("d3_mem", 64'(issue_memdata), 64'h10);
        issue_ready = 1'b1;
        cyc(); issue_ready = 1'b0;

        // Fill to capacity, then overflow attempt, then drain.
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_inst = mk(32'h0, 13'h4, 32'h0, 1'b1, 32'h100 + k, 1'b1, 5'd4);
            cyc();
        end
        #1;
        chk("d4_count_full", 64'(count), 64'd4);
        chk("d4_in_ready", 64'(in_ready), 64'd0);
        chk("d4_head", 64'(issue_rs1), 64'h100);
        in_inst = mk(32'h0, 13'h5, 32'h0, 1'b1, 32'h200, 1'b1, 5'd5);
        issue_ready = 1'b1;
        cyc(); #1;
        chk("d4_count_after_issue", 64'(count), 64'd3);
        chk("d4_head2", 64'(issue_rs1), 64'h101);
        cyc(); #1;
        chk("d4_count_enq_issue", 64'(count), 64'd3);
        chk("d4_head3", 64'(issue_rs1), 64'h102);
        in_valid = 1'b0;
        repeat (3) cyc();

        // A waits, B and C ready: B, then C, then A after wakeup.
        issue_ready = 1'b0; in_valid = 1'b1;
        in_inst = mk(32'h0, 13'h6, 32'h0, 1'b1, 32'h6, 1'b0, 5'd6); cyc();
        in_inst = mk(32'h0, 13'h7, 32'h0, 1'b1, 32'hB, 1'b1, 5'd7); cyc();
        in_inst = mk(32'h0, 13'h8, 32'h0, 1'b1, 32'hC, 1'b1, 5'd8); cyc();
        in_valid = 1'b0; issue_ready = 1'b1; #1;
        chk("d5_first_B", 64'(issue_rs1), 64'hB);
        cyc(); #1;
        chk("d5_second_C", 64'(issue_rs1), 64'hC);
        chk("d5_count", 64'(count), 64'd2);
        cyc(); #1;
        chk("d5_A_waits", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 32'hA;
        cyc(); cdb_valid = 1'b0; #1;
        chk("d5_A_rs1", 64'(issue_rs1), 64'hA);
        cyc();

        // Flush beats enqueue and issue.
        issue_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_inst = mk(32'h0, 13'h9, 32'h0, 1'b1, 32'h300 + k, 1'b1, 5'd9);
            cyc();
        end
        flush = 1'b1; issue_ready = 1'b1; #1;
        chk("d6_flush_issue", 64'(issue_valid), 64'd0);
        cyc(); flush = 1'b0; in_valid = 1'b0; issue_ready = 1'b0; #1;
        chk("d6_count", 64'(count), 64'd0);
        chk("d6_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-fill.
        in_valid = 1'b1; cyc(); cyc(); in_valid = 1'b0;
        rst_n = 1'b0; #1;
        chk("d7_count", 64'(count), 64'd0);
        chk("d7_issue_valid", 64'(issue_valid), 64'd0);
        chk("d7_in_ready", 64'(in_ready), 64'd1);
        chk("d7_rs1", 64'(issue_rs1), 64'd0);
        cyc(); rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst_n       = ($urandom_range(0, 299) != 0);
            flush       = rst_n && ($urandom_range(0, 39) == 0);
            in_valid    = 1'($urandom_range(0, 1));
            v1          = ($urandom_range(0, 2) != 0);
            v2          = ($urandom_range(0, 2) != 0);
            rs1         = $urandom;
            rs2         = $urandom;
            if (!v1) rs1[4:0] = 5'($urandom_range(0, 7));
            if (!v2) rs2[4:0] = 5'($urandom_range(0, 7));
            in_inst     = mk($urandom, 13'($urandom), rs2, v2, rs1, v1, 5'($urandom));
            cdb_valid   = ($urandom_range(0, 2) == 0);
            cdb_tag     = 5'($urandom_range(0, 7));
            cdb_data    = $urandom;
            issue_ready = ($urandom_range(0, 2) != 0);
        end
        cyc();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0;
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
